// File: rtl/fp_add_arbiter_if.sv
// Bundle between the requesters, the shared fp_add instance and fp_add_arbiter.
// master = requester/adder side, slave = arbiter side.
interface fp_add_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_dataa;
  logic [NREQ*WIDTH-1:0] req_datab;
  logic                  add_valid;
  logic [WIDTH-1:0]      add_dataa;
  logic [WIDTH-1:0]      add_datab;
  logic                  add_result_valid;
  logic [WIDTH-1:0]      add_result;
  logic [NREQ-1:0]       resp_valid;
  logic [WIDTH-1:0]      resp_result;
  logic                  busy;
  logic                  tag_error;

  modport master (
    output req_valid, req_dataa, req_datab, add_result_valid, add_result,
    input  req_ready, add_valid, add_dataa, add_datab, resp_valid, resp_result,
           busy, tag_error
  );

  modport slave (
    input  req_valid, req_dataa, req_datab, add_result_valid, add_result,
    output req_ready, add_valid, add_dataa, add_datab, resp_valid, resp_result,
           busy, tag_error
  );
endinterface

// File: rtl/fp_add_arbiter.sv
// Round-robin sharing of one pipelined fp_add between NREQ requesters, with an
// owner-tag pipe that routes each result back and flags valid-stream mismatches.
module fp_add_arbiter #(
  parameter int NREQ        = 4,
  parameter int WIDTH       = 16,
  parameter int ADD_LATENCY = 3
) (
  input  logic          clock,
  input  logic          clock_areset_n,
  input  logic          enable,
  fp_add_arbiter_if.slave bus
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IDW-1:0]   ptr_r;
  logic [IDW-1:0]   ptr_nxt_s;
  logic             grant_s;
  logic [IDW-1:0]   grant_idx_s;
  logic [NREQ-1:0]  ready_s;
  logic [WIDTH-1:0] sel_a_s;
  logic [WIDTH-1:0] sel_b_s;

  logic             add_valid_r;
  logic [WIDTH-1:0] add_dataa_r;
  logic [WIDTH-1:0] add_datab_r;
  logic [IDW-1:0]   add_id_r;

  logic [ADD_LATENCY-1:0] tag_vld_r;
  logic [IDW-1:0]         tag_id_r [ADD_LATENCY];

  logic             tag_last_vld_s;
  logic [IDW-1:0]   tag_last_id_s;
  logic             deliver_s;
  logic             mismatch_s;
  logic [NREQ-1:0]  resp_onehot_s;
  logic [NREQ-1:0]  resp_valid_r;
  logic [WIDTH-1:0] resp_result_r;
  logic             tag_error_r;

  // Round-robin search from ptr_r; reset is folded in so req_ready drops immediately.
  always_comb begin
    logic [31:0] idx_v;
    idx_v       = 32'd0;
    grant_s     = 1'b0;
    grant_idx_s = '0;
    ready_s     = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx_v = (32'(ptr_r) + 32'(k)) % 32'(NREQ);
      if (!grant_s && enable && clock_areset_n && bus.req_valid[idx_v[IDW-1:0]]) begin
        grant_s     = 1'b1;
        grant_idx_s = idx_v[IDW-1:0];
      end else begin
        grant_s     = grant_s;
      end
    end
    if (grant_s) begin
      ready_s[grant_idx_s] = 1'b1;
    end else begin
      ready_s = '0;
    end
  end

  // Pointer advance past the winner and operand lane select.
  always_comb begin
    if (grant_idx_s == IDW'(NREQ - 1)) begin
      ptr_nxt_s = '0;
    end else begin
      ptr_nxt_s = grant_idx_s + IDW'(1);
    end
    sel_a_s = bus.req_dataa[32'(grant_idx_s)*WIDTH +: WIDTH];
    sel_b_s = bus.req_datab[32'(grant_idx_s)*WIDTH +: WIDTH];
  end

  // Issue stage: pointer and registered operands toward the adder; data holds when idle.
  always_ff @(posedge clock or negedge clock_areset_n) begin
    if (!clock_areset_n) begin
      ptr_r       <= '0;
      add_valid_r <= 1'b0;
      add_dataa_r <= '0;
      add_datab_r <= '0;
      add_id_r    <= '0;
    end else begin
      add_valid_r <= grant_s;
      if (grant_s) begin
        ptr_r       <= ptr_nxt_s;
        add_dataa_r <= sel_a_s;
        add_datab_r <= sel_b_s;
        add_id_r    <= grant_idx_s;
      end else begin
        ptr_r       <= ptr_r;
        add_dataa_r <= add_dataa_r;
        add_datab_r <= add_datab_r;
        add_id_r    <= add_id_r;
      end
    end
  end

  // Owner tag pipe; its last stage lines up with the adder's result_valid.
  always_ff @(posedge clock or negedge clock_areset_n) begin
    if (!clock_areset_n) begin
      tag_vld_r <= '0;
      for (int k = 0; k < ADD_LATENCY; k++) begin
        tag_id_r[k] <= '0;
      end
    end else begin
      tag_vld_r[0] <= add_valid_r;
      tag_id_r[0]  <= add_id_r;
      for (int k = 1; k < ADD_LATENCY; k++) begin
        tag_vld_r[k] <= tag_vld_r[k-1];
        tag_id_r[k]  <= tag_id_r[k-1];
      end
    end
  end

  // A result is only routed when both streams agree; any disagreement is a mismatch.
  always_comb begin
    tag_last_vld_s = tag_vld_r[ADD_LATENCY-1];
    tag_last_id_s  = tag_id_r[ADD_LATENCY-1];
    deliver_s      = bus.add_result_valid & tag_last_vld_s;
    mismatch_s     = bus.add_result_valid ^ tag_last_vld_s;
    resp_onehot_s  = '0;
    if (deliver_s) begin
      resp_onehot_s[tag_last_id_s] = 1'b1;
    end else begin
      resp_onehot_s = '0;
    end
  end

  // Response strobe, shared result word and sticky mismatch flag.
  always_ff @(posedge clock or negedge clock_areset_n) begin
    if (!clock_areset_n) begin
      resp_valid_r  <= '0;
      resp_result_r <= '0;
      tag_error_r   <= 1'b0;
    end else begin
      resp_valid_r <= resp_onehot_s;
      tag_error_r  <= tag_error_r | mismatch_s;
      if (deliver_s) begin
        resp_result_r <= bus.add_result;
      end else begin
        resp_result_r <= resp_result_r;
      end
    end
  end

  assign bus.req_ready   = ready_s;
  assign bus.add_valid   = add_valid_r;
  assign bus.add_dataa   = add_dataa_r;
  assign bus.add_datab   = add_datab_r;
  assign bus.resp_valid  = resp_valid_r;
  assign bus.resp_result = resp_result_r;
  assign bus.busy        = add_valid_r | (|tag_vld_r);
  assign bus.tag_error   = tag_error_r;
endmodule

// File: tb/tb_fp_add_arbiter.sv
// Randomized scoreboard bench for fp_add_arbiter with a behavioural bfloat16 adder
// model and a queue-based reference of the round-robin arbitration rules.
module tb_fp_add_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 16;
  localparam int LAT   = 3;

  typedef struct {
    int               id;
    logic [WIDTH-1:0] res;
    int               cyc;
  } exp_t;

  logic clock          = 1'b0;
  logic clock_areset_n = 1'b0;
  logic enable         = 1'b0;
  logic inject         = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int n_resp = 0;
  int m_ptr  = 0;
  int last_hs = -100;
  logic             exp_av   = 1'b0;
  logic             exp_terr = 1'b0;
  logic [WIDTH-1:0] exp_a    = '0;
  logic [WIDTH-1:0] exp_b    = '0;
  logic [WIDTH-1:0] last_res = '0;
  exp_t sb[$];
  exp_t mon_e;
  int   glog[$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  fp_add_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) ifc();

  fp_add_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .ADD_LATENCY(LAT)) dut (
    .clock          (clock),
    .clock_areset_n (clock_areset_n),
    .enable         (enable),
    .bus            (ifc)
  );

  function automatic real bf2r(input logic [15:0] x);
    logic [63:0] bits;
    if (x[14:7] == 8'd0) return 0.0;
    bits = {x[15], 11'(x[14:7]) - 11'd127 + 11'd1023, x[6:0], 45'd0};
    return $bitstoreal(bits);
  endfunction

  function automatic logic [15:0] r2bf(input real r);
    logic [63:0] bits;
    bits = $realtobits(r);
    if (bits[62:52] == 11'd0) return {bits[63], 15'd0};
    return {bits[63], 8'(bits[62:52] - 11'd1023 + 11'd127), bits[51:45]};
  endfunction

  // Behavioural fp_add: real-valued sum truncated back to bfloat16.
  function automatic logic [15:0] fadd(input logic [15:0] a, input logic [15:0] b);
    return r2bf(bf2r(a) + bf2r(b));
  endfunction

  function automatic logic [NREQ*WIDTH-1:0] rand_lanes();
    logic [NREQ*WIDTH-1:0] v;
    for (int i = 0; i < NREQ; i++)
      v[i*WIDTH +: WIDTH] = {1'($urandom), 8'($urandom_range(135, 120)), 7'($urandom)};
    return v;
  endfunction

  // Adder model: LAT-deep valid/result pipe, cleared by the shared reset.
  logic [LAT-1:0]   pv;
  logic [WIDTH-1:0] pr [LAT];
  always @(posedge clock or negedge clock_areset_n) begin
    if (!clock_areset_n) begin
      pv <= '0;
      for (int k = 0; k < LAT; k++) pr[k] <= '0;
    end else begin
      pv    <= {pv[LAT-2:0], ifc.add_valid};
      pr[0] <= fadd(ifc.add_dataa, ifc.add_datab);
      for (int k = 1; k < LAT; k++) pr[k] <= pr[k-1];
    end
  end
  assign ifc.add_result_valid = pv[LAT-1] | inject;
  assign ifc.add_result       = pr[LAT-1];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    n_chk++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, expv, cyc);
    end
  endtask

  function automatic logic busy_exp();
    return (cyc - last_hs >= 1) && (cyc - last_hs <= LAT + 1);
  endfunction

  // Monitor: pops the scoreboard whenever a response strobe appears or is overdue.
  always @(negedge clock) begin
    if (clock_areset_n) begin
      if (ifc.resp_valid != '0) begin
        if (sb.size() == 0) begin
          chk("resp_unexpected", 32'(ifc.resp_valid), 32'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("resp_owner", 32'(ifc.resp_valid), 32'd1 << mon_e.id);
          chk("resp_result", 32'(ifc.resp_result), 32'(mon_e.res));
          chk("resp_latency", cyc, mon_e.cyc);
          last_res = ifc.resp_result;
          n_resp++;
        end
      end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
        chk("resp_missing", 32'(ifc.resp_valid), 32'd1 << sb[0].id);
        void'(sb.pop_front());
      end
    end
  end

  // One clock of stimulus: check the previous cycle's effects, drive, predict the grant.
  task automatic step(input logic [NREQ-1:0] req, input logic en, input logic inj,
                      input logic [NREQ*WIDTH-1:0] da, input logic [NREQ*WIDTH-1:0] db);
    int g;
    @(negedge clock);
    chk("add_valid", 32'(ifc.add_valid), 32'(exp_av));
    chk("add_dataa", 32'(ifc.add_dataa), 32'(exp_a));
    chk("add_datab", 32'(ifc.add_datab), 32'(exp_b));
    chk("busy", 32'(ifc.busy), 32'(busy_exp()));
    chk("tag_error", 32'(ifc.tag_error), 32'(exp_terr));
    ifc.req_valid = req;
    ifc.req_dataa = da;
    ifc.req_datab = db;
    enable        = en;
    inject        = inj;
    #1;
    g = -1;
    if (en) begin
      for (int k = 0; k < NREQ; k++)
        if (g < 0 && req[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
    end
    chk("req_ready", 32'(ifc.req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
    for (int k = 0; k < NREQ; k++)
      if (ifc.req_ready[k]) glog.push_back(k);
    if (g >= 0) begin
      exp_a = da[g*WIDTH +: WIDTH];
      exp_b = db[g*WIDTH +: WIDTH];
      sb.push_back('{g, fadd(exp_a, exp_b), cyc + LAT + 2});
      m_ptr   = (g + 1) % NREQ;
      last_hs = cyc;
      exp_av  = 1'b1;
    end else begin
      exp_av  = 1'b0;
    end
    if (inj) exp_terr = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, 1'b1, 1'b0, '0, '0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    #2;
    clock_areset_n = 1'b0;
    #1;
    chk("rst_req_ready", 32'(ifc.req_ready), 32'd0);
    chk("rst_add_valid", 32'(ifc.add_valid), 32'd0);
    chk("rst_add_dataa", 32'(ifc.add_dataa), 32'd0);
    chk("rst_add_datab", 32'(ifc.add_datab), 32'd0);
    chk("rst_resp_valid", 32'(ifc.resp_valid), 32'd0);
    chk("rst_resp_result", 32'(ifc.resp_result), 32'd0);
    chk("rst_busy", 32'(ifc.busy), 32'd0);
    chk("rst_tag_error", 32'(ifc.tag_error), 32'd0);
    ifc.req_valid = '0;
    inject        = 1'b0;
    sb.delete();
    glog.delete();
    m_ptr    = 0;
    last_hs  = -100;
    exp_av   = 1'b0;
    exp_a    = '0;
    exp_b    = '0;
    exp_terr = 1'b0;
    @(posedge clock);
    @(negedge clock);
    #2;
    clock_areset_n = 1'b1;
  endtask

  initial begin
    logic [NREQ*WIDTH-1:0] da;
    logic [NREQ*WIDTH-1:0] db;
    ifc.req_valid = '0;
    ifc.req_dataa = '0;
    ifc.req_datab = '0;
    do_reset();

    // Single op: 1.0 + 2.0 on requester 0.
    da = '0; db = '0;
    da[WIDTH-1:0] = 16'h3F80;
    db[WIDTH-1:0] = 16'h4000;
    step(4'b0001, 1'b1, 1'b0, da, db);
    idle(7);
    chk("single_result", 32'(last_res), 32'h4040);
    chk("single_count", n_resp, 1);

    // Round-robin fairness with all requesters active.
    do_reset();
    for (int i = 0; i < 8; i++) step(4'b1111, 1'b1, 1'b0, rand_lanes(), rand_lanes());
    idle(7);
    chk("rr_count", glog.size(), 8);
    for (int i = 0; i < glog.size(); i++) chk("rr_order", glog[i], i % 4);

    // Pointer wrap and skip of idle requesters.
    do_reset();
    step(4'b0100, 1'b1, 1'b0, rand_lanes(), rand_lanes());
    for (int i = 0; i < 4; i++) step(4'b0101, 1'b1, 1'b0, rand_lanes(), rand_lanes());
    idle(7);
    chk("skip_count", glog.size(), 5);
    for (int i = 0; i < glog.size(); i++) chk("skip_order", glog[i], (i % 2 == 0) ? 2 : 0);

    // Enable gating, then resume from the held pointer.
    do_reset();
    step(4'b1111, 1'b1, 1'b0, rand_lanes(), rand_lanes());
    step(4'b1111, 1'b1, 1'b0, rand_lanes(), rand_lanes());
    for (int i = 0; i < 6; i++) step(4'b1111, 1'b0, 1'b0, rand_lanes(), rand_lanes());
    step(4'b1111, 1'b1, 1'b0, rand_lanes(), rand_lanes());
    idle(7);
    chk("en_count", glog.size(), 3);
    if (glog.size() == 3) chk("en_resume", glog[2], 2);

    // Mismatch: result_valid with an empty tag pipe.
    do_reset();
    step('0, 1'b1, 1'b1, '0, '0);
    step('0, 1'b1, 1'b0, '0, '0);
    chk("mm_resp_valid", 32'(ifc.resp_valid), 32'd0);
    idle(4);
    chk("mm_sticky", 32'(ifc.tag_error), 32'd1);

    // Async reset with three ops in flight.
    do_reset();
    for (int i = 0; i < 3; i++) step(4'b1111, 1'b1, 1'b0, rand_lanes(), rand_lanes());
    do_reset();
    idle(8);
    chk("mf_tag_error", 32'(ifc.tag_error), 32'd0);
    chk("mf_no_stale", sb.size(), 0);

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 400; i++)
      step(4'($urandom), ($urandom_range(9, 0) != 0), 1'b0, rand_lanes(), rand_lanes());
    idle(8);
    chk("sb_drain", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fp_add_arbiter.md
Name: fp_add_arbiter

Overview:
Shares one pipelined fp_add instance between NREQ independent requesters in the CNN datapath, such as per-channel partial-sum accumulators. The block arbitrates round-robin among requesters, issues one operand pair per cycle to the adder and tracks the owner of each in-flight operation in a tag pipeline matched to the adder latency. It returns each result to its owner with a one-hot response strobe and flags any mismatch between the adder's valid stream and the tag stream.

Parameters:
NREQ, 4, number of requesters (2..16)
WIDTH, 16, float word width (sign+exp+mant), must match the adder
ADD_LATENCY, 3, cycles from adder data_valid to result_valid (3 for fp_add with EXTRA_PIPELINE=2)

Ports:
clock  in  1  system clock
clock_areset_n  in  1  asynchronous active-low reset
enable  in  1  when low, no new grants are made; in-flight ops complete
req_valid  in  NREQ  per-requester operand valid
req_ready  out  NREQ  per-requester accept (one-hot or zero)
req_dataa  in  NREQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
req_datab  in  NREQ*WIDTH  operand B, same packing
add_valid  out  1  to fp_add data_valid
add_dataa  out  WIDTH  to fp_add dataa
add_datab  out  WIDTH  to fp_add datab
add_result_valid  in  1  from fp_add result_valid
add_result  in  WIDTH  from fp_add result
resp_valid  out  NREQ  one-hot result strobe to the owner
resp_result  out  WIDTH  result word, shared by all requesters
busy  out  1  high while any op is issued-but-unreturned
tag_error  out  1  sticky mismatch flag

Behaviour:
- Reset (async, clock_areset_n=0) clears the following immediately: req_ready=0, add_valid=0, add_dataa=0, add_datab=0, resp_valid=0, resp_result=0, busy=0, tag_error=0, RR pointer=0, all tag-pipe valids=0.
- Handshake: a transfer occurs on a rising edge where req_valid[i]&req_ready[i]. req_ready is combinational from req_valid, the pointer and enable. At most one bit of req_ready is high per cycle. req_ready=0 while enable=0.
- Arbitration: search starts at index ptr and wraps modulo NREQ. The first requester with valid high is granted. After a grant, ptr <= (grant_idx+1) mod NREQ. With no grant, ptr holds.
- Issue: the granted operands are registered. add_valid=1 with add_dataa/add_datab in the cycle after the handshake. In cycles with no grant, add_valid=0 and the data holds its last value.
- Tag pipe: ADD_LATENCY stages of {valid, id[$clog2(NREQ)-1:0]}. Stage 0 loads when add_valid is driven, and stages shift every cycle. The pipe has no stall; the adder has no backpressure.
- Return: when add_result_valid=1 and the last tag stage is valid, on the next edge resp_valid[id]=1 and resp_result=add_result, for one cycle. Otherwise resp_valid=0 and resp_result holds.
- Latency: handshake at edge t gives add_valid during cycle t+1 and resp_valid during cycle t+2+ADD_LATENCY. This is 5 cycles with the default parameters.
- Throughput: 1 op/cycle sustained. Back-to-back grants to the same requester are allowed when it is the only one requesting.
- Mismatch: if add_result_valid and the last tag valid differ in any cycle, tag_error is set. The result (if any) is discarded and resp_valid stays 0. tag_error clears only on reset.
- busy = add_valid OR any tag-stage valid.
- Responses have no backpressure; requesters must always accept resp_valid.
- Reset mid-operation: all in-flight tags are dropped and no responses are issued for them. The integrator drives fp_add clock_sreset from the same reset source so stale adder valids do not trip tag_error.
- enable falling with requests pending: grants stop at the next cycle and in-flight ops still return. When enable rises again, arbitration resumes from the held ptr.

Test Plan:
- Single op: reset, then req_valid=0001 with A=0x3F80 (1.0), B=0x4000 (2.0) for one handshake -> add_valid in the next cycle; with a behavioural fp_add model, resp_valid=0001 and resp_result=0x4040 (3.0) exactly 5 cycles after the handshake; busy high throughout, then 0.
- Round-robin fairness: req_valid=1111 held for 8 cycles -> grant order 0,1,2,3,0,1,2,3; resp_valid sequence 0001,0010,0100,1000 repeated, each 5 cycles after its grant.
- Pointer wrap/skip: ptr=3 after a grant to 2, then req_valid=0101 -> next grant 0, then 2, then 0; no grant ever goes to 1 or 3.
- Enable gating: req_valid=1111 with enable dropped after 2 grants -> req_ready=0 from the next cycle; the two in-flight responses still arrive; re-enabling resumes at index 2.
- Mismatch: force add_result_valid=1 with an empty tag pipe -> tag_error=1 one cycle later, resp_valid stays 0, and tag_error stays high until reset.
- Async reset mid-flight: assert clock_areset_n=0 between clock edges with 3 ops in flight -> all outputs 0 immediately; after release no stale resp_valid appears and tag_error=0.
